led_display_pwm_gen: RTL and testbench



---
 rtl/led_display_pkg.sv | 20 ++
 rtl/led_display_pwm_channel.sv | 53 +++++
 rtl/led_display_pwm_gen.sv | 79 +++++++
 tb/tb_led_display_pwm_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// ============================================================================
// Module   : led_display_pkg
// Brief    : Shared constants and helpers for the LED display PWM path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_display_pkg;

  localparam int DUTY_WIDTH = 8;
  localparam int DUTY_MAX   = 255;

  // PWM period in system clock cycles.
  function automatic int pwm_period(input int sys_clk_freq, input int pwm_freq);
    return sys_clk_freq / pwm_freq;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_display_pwm_channel.sv
// ============================================================================
// Module   : led_display_pwm_channel
// Brief    : One colour channel: duty-to-threshold scaling, period-aligned
//            threshold reload and registered compare output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_pwm_channel
  import led_display_pkg::*;
#(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = $clog2(PERIOD),
  parameter int THR_W  = $clog2(PERIOD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [CNT_W-1:0]      i_cnt,
  input  logic [DUTY_WIDTH-1:0] i_duty,
  output logic                  o_pwm
);

  localparam int c_prod_w = DUTY_WIDTH + THR_W;

  logic [c_prod_w-1:0] w_prod;
  logic [THR_W-1:0]    w_thr;
  logic [THR_W-1:0]    r_thr;
  logic                r_pwm;

  // Floor scaling so that full-scale duty maps exactly onto PERIOD.
  assign w_prod = c_prod_w'(i_duty) * c_prod_w'(PERIOD);
  assign w_thr  = THR_W'(w_prod / c_prod_w'(DUTY_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr <= '0;
      r_pwm <= 1'b0;
    end else begin
      // Idle: follow the duty input so the first enabled period uses it.
      if (!i_enable || i_load) begin
        r_thr <= w_thr;
      end
      r_pwm <= i_enable && (THR_W'(i_cnt) < r_thr);
    end
  end

  assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/led_display_pwm_gen.sv
// ============================================================================
// Module   : led_display_pwm_gen
// Brief    : Three-channel (R/G/B) brightness PWM generator with a shared
//            free-running period counter and period-start strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_pwm_gen
  import led_display_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int PWM_FREQ     = 100_000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic [DUTY_WIDTH-1:0] duty_r_in,
  input  logic [DUTY_WIDTH-1:0] duty_g_in,
  input  logic [DUTY_WIDTH-1:0] duty_b_in,
  output logic                  pwm_r_out,
  output logic                  pwm_g_out,
  output logic                  pwm_b_out,
  output logic                  period_strobe_out
);

  localparam int c_period = pwm_period(SYS_CLK_FREQ, PWM_FREQ);
  localparam int c_cnt_w  = $clog2(c_period);
  localparam int c_thr_w  = $clog2(c_period + 1);

  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_strobe;
  logic                  w_wrap;
  logic [DUTY_WIDTH-1:0] w_duty [3];
  logic [2:0]            w_pwm;

  assign w_wrap = (r_cnt == c_cnt_w'(c_period - 1));

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else if (!enable_in) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= (r_cnt == '0);
      r_cnt    <= w_wrap ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  assign w_duty[0] = duty_r_in;
  assign w_duty[1] = duty_g_in;
  assign w_duty[2] = duty_b_in;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    led_display_pwm_channel #(
      .PERIOD (c_period),
      .CNT_W  (c_cnt_w),
      .THR_W  (c_thr_w)
    ) u_chan (
      .clk      (clk_in),
      .rst      (reset_in),
      .i_enable (enable_in),
      .i_load   (w_wrap),
      .i_cnt    (r_cnt),
      .i_duty   (w_duty[i]),
      .o_pwm    (w_pwm[i])
    );
  end

  assign pwm_r_out         = w_pwm[0];
  assign pwm_g_out         = w_pwm[1];
  assign pwm_b_out         = w_pwm[2];
  assign period_strobe_out = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_led_display_pwm_gen.sv
// ============================================================================
// Module   : tb_led_display_pwm_gen
// Brief    : Directed self-checking bench for led_display_pwm_gen (defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_pwm_gen;

  localparam int PERIOD = 1000;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       enable_in;
  logic [7:0] duty_r_in, duty_g_in, duty_b_in;
  logic       pwm_r_out, pwm_g_out, pwm_b_out, period_strobe_out;
  logic [2:0] pwm_v;

  int n_cmp  = 0;
  int n_fail = 0;

  // Results of the most recent measured period, written by count_period.
  int p_hi    [3];
  int p_runs  [3];
  int p_start [3];
  int p_extra;
  int p_next;
  bit s_found;

  led_display_pwm_gen dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .enable_in         (enable_in),
    .duty_r_in         (duty_r_in),
    .duty_g_in         (duty_g_in),
    .duty_b_in         (duty_b_in),
    .pwm_r_out         (pwm_r_out),
    .pwm_g_out         (pwm_g_out),
    .pwm_b_out         (pwm_b_out),
    .period_strobe_out (period_strobe_out)
  );

  always #5 clk_in = ~clk_in;

  assign pwm_v = {pwm_b_out, pwm_g_out, pwm_r_out};

  // Bounded search for a strobe, sampling on falling edges.
  task automatic wait_strobe();
    s_found = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 4; i++) begin
      if (period_strobe_out === 1'b1) begin
        s_found = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  // Observe one period starting at a strobe sample; optionally change duty_r
  // at cycle chg_at. Leaves the bench on the sample of the following cycle.
  task automatic count_period(input int chg_at, input logic [7:0] chg_val);
    logic [2:0] prev;
    prev = 3'b000;
    p_extra = 0;
    for (int c = 0; c < 3; c++) begin
      p_hi[c] = 0; p_runs[c] = 0; p_start[c] = 0;
    end
    for (int i = 0; i < PERIOD; i++) begin
      if (i == chg_at) duty_r_in = chg_val;
      if (i > 0 && period_strobe_out === 1'b1) p_extra++;
      for (int c = 0; c < 3; c++) begin
        if (pwm_v[c] === 1'b1) begin
          p_hi[c]++;
          if (prev[c] !== 1'b1) p_runs[c]++;
          if (i == 0) p_start[c] = 1;
        end
      end
      prev = pwm_v;
      @(negedge clk_in);
    end
    p_next = (period_strobe_out === 1'b1) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; enable_in = 1'b0;
    duty_r_in = 8'd0; duty_g_in = 8'd0; duty_b_in = 8'd0;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (pwm_v !== 3'b000) begin
      n_fail++; $display("FAIL reset_pwm: got %b expected 000", pwm_v);
    end
    n_cmp++;
    if (period_strobe_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobe: got %b expected 0", period_strobe_out);
    end
    reset_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    int exp_hi [3];
    int exp_runs [3];
    exp_hi = '{0, 1000, 501};
    exp_runs = '{0, 1, 1};
    duty_r_in = 8'd0; duty_g_in = 8'd255; duty_b_in = 8'd128;
    @(negedge clk_in);
    enable_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (period_strobe_out !== 1'b1) begin
      n_fail++; $display("FAIL basic_first_strobe: got %b expected 1", period_strobe_out);
    end
    for (int p = 0; p < 5; p++) begin
      count_period(-1, 8'd0);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (p_hi[c] !== exp_hi[c] || p_runs[c] !== exp_runs[c] || p_start[c] !== exp_runs[c]) begin
          n_fail++;
          $display("FAIL basic_p%0d_ch%0d: high=%0d runs=%0d start=%0d expected high=%0d runs=%0d start=%0d",
                   p, c, p_hi[c], p_runs[c], p_start[c], exp_hi[c], exp_runs[c], exp_runs[c]);
        end
      end
      n_cmp++;
      if (p_extra !== 0 || p_next !== 1) begin
        n_fail++; $display("FAIL basic_p%0d_strobe_gap: extra=%0d next=%0d expected 0 and 1", p, p_extra, p_next);
      end
    end
  endtask

  task automatic test_duty64();
    duty_r_in = 8'd64; duty_g_in = 8'd64; duty_b_in = 8'd64;
    // Current period was loaded before the change.
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 0 || p_hi[1] !== 1000 || p_hi[2] !== 501) begin
      n_fail++; $display("FAIL duty64_old_period: got %0d/%0d/%0d expected 0/1000/501", p_hi[0], p_hi[1], p_hi[2]);
    end
    for (int p = 0; p < 2; p++) begin
      count_period(-1, 8'd0);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (p_hi[c] !== 250 || p_runs[c] !== 1 || p_start[c] !== 1) begin
          n_fail++;
          $display("FAIL duty64_p%0d_ch%0d: high=%0d runs=%0d start=%0d expected high=250 runs=1 start=1",
                   p, c, p_hi[c], p_runs[c], p_start[c]);
        end
      end
      n_cmp++;
      if (p_extra !== 0 || p_next !== 1) begin
        n_fail++; $display("FAIL duty64_p%0d_strobe_gap: extra=%0d next=%0d expected 0 and 1", p, p_extra, p_next);
      end
    end
  endtask

  task automatic test_duty_change();
    count_period(500, 8'd192);
    n_cmp++;
    if (p_hi[0] !== 250 || p_hi[1] !== 250 || p_hi[2] !== 250) begin
      n_fail++; $display("FAIL change_current: got %0d/%0d/%0d expected 250/250/250", p_hi[0], p_hi[1], p_hi[2]);
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 752 || p_start[0] !== 1 || p_runs[0] !== 1) begin
      n_fail++; $display("FAIL change_next_r: high=%0d start=%0d runs=%0d expected 752 1 1", p_hi[0], p_start[0], p_runs[0]);
    end
    n_cmp++;
    if (p_hi[1] !== 250 || p_hi[2] !== 250) begin
      n_fail++; $display("FAIL change_next_gb: got %0d/%0d expected 250/250", p_hi[1], p_hi[2]);
    end
  endtask

  task automatic test_reset_start();
    reset_in = 1'b1; enable_in = 1'b1;
    duty_r_in = 8'd255; duty_g_in = 8'd255; duty_b_in = 8'd255;
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    wait_strobe();
    n_cmp++;
    if (!s_found) begin
      n_fail++; $display("FAIL rst_start_strobe: strobe seen=0 expected 1");
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 0 || p_hi[1] !== 0 || p_hi[2] !== 0 || p_next !== 1) begin
      n_fail++; $display("FAIL rst_start_dark: got %0d/%0d/%0d next=%0d expected 0/0/0 next=1",
                         p_hi[0], p_hi[1], p_hi[2], p_next);
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 1000 || p_hi[1] !== 1000 || p_hi[2] !== 1000) begin
      n_fail++; $display("FAIL rst_start_full: got %0d/%0d/%0d expected 1000/1000/1000", p_hi[0], p_hi[1], p_hi[2]);
    end
  endtask

  task automatic test_disable();
    repeat (300) @(negedge clk_in);
    n_cmp++;
    if (pwm_v !== 3'b111) begin
      n_fail++; $display("FAIL dis_before: got %b expected 111", pwm_v);
    end
    enable_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (pwm_v !== 3'b000 || period_strobe_out !== 1'b0) begin
      n_fail++; $display("FAIL dis_next_edge: pwm=%b strobe=%b expected 000 0", pwm_v, period_strobe_out);
    end
    duty_r_in = 8'd64; duty_g_in = 8'd0; duty_b_in = 8'd255;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (pwm_v !== 3'b000) begin
      n_fail++; $display("FAIL dis_idle: got %b expected 000", pwm_v);
    end
    enable_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (period_strobe_out !== 1'b1) begin
      n_fail++; $display("FAIL reen_strobe: got %b expected 1", period_strobe_out);
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 250 || p_hi[1] !== 0 || p_hi[2] !== 1000 || p_start[0] !== 1 || p_start[2] !== 1) begin
      n_fail++; $display("FAIL reen_duties: got %0d/%0d/%0d start r=%0d b=%0d expected 250/0/1000 start 1 1",
                         p_hi[0], p_hi[1], p_hi[2], p_start[0], p_start[2]);
    end
  endtask

  task automatic test_async_reset();
    repeat (100) @(negedge clk_in);
    n_cmp++;
    if (pwm_v !== 3'b101) begin
      n_fail++; $display("FAIL arst_before: got %b expected 101", pwm_v);
    end
    #2 reset_in = 1'b1;
    #1;
    n_cmp++;
    if (pwm_v !== 3'b000 || period_strobe_out !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: pwm=%b strobe=%b expected 000 0", pwm_v, period_strobe_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (period_strobe_out !== 1'b1) begin
      n_fail++; $display("FAIL arst_first_strobe: got %b expected 1", period_strobe_out);
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 0 || p_hi[1] !== 0 || p_hi[2] !== 0) begin
      n_fail++; $display("FAIL arst_dark: got %0d/%0d/%0d expected 0/0/0", p_hi[0], p_hi[1], p_hi[2]);
    end
    count_period(-1, 8'd0);
    n_cmp++;
    if (p_hi[0] !== 250 || p_hi[1] !== 0 || p_hi[2] !== 1000) begin
      n_fail++; $display("FAIL arst_after: got %0d/%0d/%0d expected 250/0/1000", p_hi[0], p_hi[1], p_hi[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty64();
    test_duty_change();
    test_reset_start();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
